axi_lite_cmd_master: RTL and testbench
======================================

// Module: axi_lite_cmd_master
// PURPOSE
//  Synthesizable AXI4-Lite initiator that replaces bench-style register poking of Axi_Lite_Uart.
//  Accepts one single-beat read or write command on a simple valid/ready port.
//  Runs the full AXI-Lite transaction and returns read data or write status on a response port.
//  Sits between a local controller (CPU-less FSM, test sequencer) and any AXI-Lite slave in the UART IP.
// PARAMETERS
//  P_M_AXI_ADDR_WIDTH  32    address width
//  P_M_AXI_DATA_WIDTH  32    data width; wstrb width = P_M_AXI_DATA_WIDTH/8
//  P_TIMEOUT_CYCLES    1024  cycles allowed per channel wait before abort; 0 = never time out
// PORTS
//  m_axi_aclk     in   1    clock
//  m_axi_aresetn  in   1    async active-low reset
//  cmd_valid      in   1    command present
//  cmd_ready      out  1    command accepted when cmd_valid & cmd_ready
//  cmd_write      in   1    1 = write, 0 = read
//  cmd_addr       in   AW   byte address
//  cmd_wdata      in   DW   write data
//  cmd_wstrb      in   DW/8 write strobes
//  rsp_valid      out  1    response present, held until rsp_ready
//  rsp_ready      in   1    response consumed
//  rsp_rdata      out  DW   read data; 0 for writes
//  rsp_resp       out  2    BRESP/RRESP; 2'b10 on timeout
//  rsp_timeout    out  1    transaction aborted by timeout
//  m_axi_aw*/w*/b*/ar*/r*   standard AXI4-Lite master signals; awprot = arprot = 3'b000
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; rsp_valid=0; all *valid=0; bready=rready=0; rsp_* data=0.
//  States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
//  IDLE: on cmd_valid&cmd_ready latch addr/wdata/wstrb/write, drop cmd_ready.
//   Next cycle drive awvalid=wvalid=1 (WR) or arvalid=1 (RD_ADDR). Command-to-valid latency is 1 cycle.
//  WR: AW and W run concurrently; each valid drops the cycle after its own handshake.
//   Either order and same-cycle acceptance are all legal.
//   bready=1 from entry to WR. When both handshakes are done -> WR_RESP.
//   If bvalid arrives in the same cycle as the last of AW/W, it is accepted and the FSM goes straight to RSP.
//  WR_RESP: on bvalid&bready capture bresp, drop bready -> RSP.
//  RD_ADDR: rready=1 from entry. On arvalid&arready drop arvalid -> RD_DATA.
//   If rvalid arrives in the same cycle, capture it and go to RSP.
//  RD_DATA: on rvalid&rready capture rdata/rresp, drop rready -> RSP.
//  RSP: rsp_valid=1 with stable outputs until rsp_ready. On handshake -> IDLE with cmd_ready=1 the next cycle.
//   Back-to-back commands therefore have 1 bubble cycle.
//  Valids stay asserted until their handshake; addr/data are stable while valid.
//  Timeout: counter clears on each state entry and on every handshake, and increments while waiting in WR/WR_RESP/RD_ADDR/RD_DATA.
//   At P_TIMEOUT_CYCLES: deassert all valids/readies, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0 -> RSP.
//   The counter saturates. Late slave responses after an abort are ignored: bready/rready are 0.
//  Reset asserted mid-transaction returns immediately to reset values, with no response generated.
//  Write latency with a zero-wait slave: cmd accept -> rsp_valid = 4 cycles. Read latency = 4 cycles.
// TESTING
//  1 Write 0x4 <= 0x6, wstrb 0xF, zero-wait slave -> one AW and one W beat, awaddr=0x4, wdata=0x6; rsp_resp=00, rsp_timeout=0.
//  2 Read 0x0, slave returns 0x0000_00A5 after 3 wait cycles -> rsp_rdata=0xA5, rsp_resp=00; arvalid high exactly until arready.
//  3 Write with wready 5 cycles after awready, bresp=2'b10 -> awvalid drops first; rsp_resp=10, rsp_timeout=0.
//  4 P_TIMEOUT_CYCLES=16, slave never raises arready -> rsp_valid after 16+1 cycles; rsp_resp=10, rsp_timeout=1, arvalid=0.
//  5 rsp_ready held low 10 cycles -> rsp_* stable and cmd_ready=0 throughout; a queued cmd is accepted 1 cycle after the rsp handshake.
//  6 Reset pulsed while awvalid=1 -> all valids 0 and cmd_ready=1 after reset; a following read of 0x0 completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: takes one read/write command, runs the
// AXI-Lite handshakes, and returns data/status (or a timeout abort) on a response port.
module axi_lite_cmd_master #(
    parameter int unsigned P_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned P_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_aresetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [P_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [P_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    output logic [P_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [P_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    input  logic [1:0]                        m_axi_bresp,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp
);
    localparam int unsigned AW = P_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = P_M_AXI_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TW = $clog2(P_TIMEOUT_CYCLES + 2);
    localparam bit          TMO_EN = (P_TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(P_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP} state_t;

    state_t          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic            bready_q, bready_d, rready_q, rready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;

    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, tmo_hit, finish, abort;
    logic [1:0]      cap_resp;
    logic [DW-1:0]   cap_data;

    assign aw_hs   = awvalid_q & m_axi_awready;
    assign w_hs    = wvalid_q & m_axi_wready;
    assign b_hs    = bready_q & m_axi_bvalid;
    assign ar_hs   = arvalid_q & m_axi_arready;
    assign r_hs    = rready_q & m_axi_rvalid;
    assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LIMIT);
    assign tmo_inc = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + TW'(1);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        tmo_cnt_d     = tmo_cnt_q;
        finish        = 1'b0;
        abort         = 1'b0;
        cap_resp      = 2'b00;
        cap_data      = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cmd_ready_d = 1'b0;
                    tmo_cnt_d   = '0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                awvalid_d = awvalid_q & ~aw_hs;
                wvalid_d  = wvalid_q & ~w_hs;
                if (!awvalid_d && !wvalid_d) begin
                    // bready is already high, so a B beat coincident with the last AW/W is taken here
                    if (b_hs) begin
                        finish   = 1'b1;
                        cap_resp = m_axi_bresp;
                    end else begin
                        state_d   = S_WR_RESP;
                        tmo_cnt_d = '0;
                    end
                end else if (aw_hs || w_hs) begin
                    tmo_cnt_d = '0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    finish   = 1'b1;
                    cap_resp = m_axi_bresp;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    if (r_hs) begin
                        finish   = 1'b1;
                        cap_resp = m_axi_rresp;
                        cap_data = m_axi_rdata;
                    end else begin
                        state_d   = S_RD_DATA;
                        tmo_cnt_d = '0;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            S_RD_DATA: begin
                if (r_hs) begin
                    finish   = 1'b1;
                    cap_resp = m_axi_rresp;
                    cap_data = m_axi_rdata;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion and abort share one exit; an abort leaves readies low so late beats are ignored
        if (finish || abort) begin
            state_d       = S_RSP;
            rsp_valid_d   = 1'b1;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            tmo_cnt_d     = '0;
            rsp_timeout_d = abort;
            rsp_resp_d    = abort ? 2'b10 : cap_resp;
            rsp_rdata_d   = abort ? '0 : cap_data;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a small programmable-wait AXI-Lite slave.
module tb_axi_lite_cmd_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad = 0;

    // slave knobs and observations
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_val = 2'b00;
    logic [31:0] rdata_val = '0;
    int          aw_cnt, w_cnt, ar_cnt;
    bit          aw_got, w_got, ar_got;
    int          aw_beats = 0, w_beats = 0, ar_beats = 0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0;
    logic [3:0]  w_strb_seen = '0;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .P_M_AXI_ADDR_WIDTH(32), .P_M_AXI_DATA_WIDTH(32), .P_TIMEOUT_CYCLES(16)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid && (w_cnt >= w_delay);
    assign arready = arvalid && (ar_cnt >= ar_delay);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) begin aw_got <= 1'b1; aw_beats <= aw_beats + 1; aw_addr_seen <= awaddr; end
            if (wvalid && wready) begin
                w_got <= 1'b1; w_beats <= w_beats + 1; w_data_seen <= wdata; w_strb_seen <= wstrb;
            end
            if (arvalid && arready) begin ar_got <= 1'b1; ar_beats <= ar_beats + 1; ar_addr_seen <= araddr; end
            if (bvalid && bready) bvalid <= 1'b0;
            else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1; bresp <= bresp_val; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            else if (!rvalid && (ar_got || (arvalid && arready))) begin
                rvalid <= 1'b1; rdata <= rdata_val; rresp <= 2'b00; ar_got <= 1'b0;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output bit ok);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        ok = (n < 50);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Latency is counted with the accept cycle as cycle 1; valids are tallied per cycle high.
    task automatic wait_rsp(output int cyc, output int aw_c, output int w_c, output int ar_c, output bit aw_first);
        cyc = 2; aw_c = 0; w_c = 0; ar_c = 0; aw_first = 1'b0;
        while (!rsp_valid && cyc < 200) begin
            if (awvalid) aw_c++;
            if (wvalid) w_c++;
            if (arvalid) ar_c++;
            if (!awvalid && wvalid) aw_first = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if ({rsp_valid, awvalid, wvalid, arvalid, bready, rready} !== 6'b0) begin
            bad++; $display("FAIL reset_valids got=%b want=000000", {rsp_valid, awvalid, wvalid, arvalid, bready, rready});
        end
        total++; if ({rsp_rdata, rsp_resp, rsp_timeout, awprot, arprot} !== 41'b0) begin
            bad++; $display("FAIL reset_rsp got=%h/%b/%b want=0/00/0", rsp_rdata, rsp_resp, rsp_timeout);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        bit ok, awf; int lat, ac, wc, rc, awb, wb;
        awb = aw_beats; wb = w_beats;
        aw_delay = 0; w_delay = 0; bresp_val = 2'b00;
        do_cmd(1'b1, 32'h4, 32'h6, 4'hF, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b want=1", ok); end
        total++; if ({awvalid, wvalid} !== 2'b11) begin bad++; $display("FAIL wr_valid_lat got=%b want=11", {awvalid, wvalid}); end
        wait_rsp(lat, ac, wc, rc, awf);
        total++; if (lat !== 4) begin bad++; $display("FAIL wr_latency got=%0d want=4", lat); end
        total++; if ((aw_beats - awb) !== 1 || (w_beats - wb) !== 1) begin
            bad++; $display("FAIL wr_beats got=%0d/%0d want=1/1", aw_beats - awb, w_beats - wb);
        end
        total++; if ({aw_addr_seen, w_data_seen, w_strb_seen} !== {32'h4, 32'h6, 4'hF}) begin
            bad++; $display("FAIL wr_payload got=%h/%h/%h want=4/6/f", aw_addr_seen, w_data_seen, w_strb_seen);
        end
        total++; if ({rsp_resp, rsp_timeout, rsp_rdata} !== 35'b0) begin
            bad++; $display("FAIL wr_rsp got=%b/%b/%h want=00/0/0", rsp_resp, rsp_timeout, rsp_rdata);
        end
        consume();
    endtask

    task automatic test_read_wait();
        bit ok, awf; int lat, ac, wc, rc;
        ar_delay = 3; rdata_val = 32'hA5;
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, ok);
        wait_rsp(lat, ac, wc, rc, awf);
        total++; if (rc !== 4) begin bad++; $display("FAIL rd_arvalid_cycles got=%0d want=4", rc); end
        total++; if (lat !== 7) begin bad++; $display("FAIL rd_latency got=%0d want=7", lat); end
        total++; if ({rsp_rdata, rsp_resp, rsp_timeout, arvalid} !== {32'hA5, 2'b00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rd_rsp got=%h/%b/%b want=a5/00/0", rsp_rdata, rsp_resp, rsp_timeout);
        end
        total++; if (ar_addr_seen !== 32'h0) begin bad++; $display("FAIL rd_addr got=%h want=0", ar_addr_seen); end
        consume();
        ar_delay = 0;
    endtask

    task automatic test_write_slow_w();
        bit ok, awf; int lat, ac, wc, rc;
        w_delay = 5; bresp_val = 2'b10;
        do_cmd(1'b1, 32'hC, 32'h1234, 4'h3, ok);
        wait_rsp(lat, ac, wc, rc, awf);
        total++; if ({ac, wc} !== {32'd1, 32'd6}) begin bad++; $display("FAIL slow_w_cycles got=%0d/%0d want=1/6", ac, wc); end
        total++; if (awf !== 1'b1) begin bad++; $display("FAIL slow_w_aw_first got=%b want=1", awf); end
        total++; if (lat !== 9) begin bad++; $display("FAIL slow_w_latency got=%0d want=9", lat); end
        total++; if ({rsp_resp, rsp_timeout} !== 3'b100) begin
            bad++; $display("FAIL slow_w_rsp got=%b/%b want=10/0", rsp_resp, rsp_timeout);
        end
        consume();
        w_delay = 0; bresp_val = 2'b00;
    endtask

    task automatic test_timeout();
        bit ok, awf; int lat, ac, wc, rc;
        ar_delay = 1000;
        do_cmd(1'b0, 32'h10, 32'h0, 4'h0, ok);
        wait_rsp(lat, ac, wc, rc, awf);
        total++; if (rc !== 17) begin bad++; $display("FAIL tmo_arvalid_cycles got=%0d want=17", rc); end
        total++; if (lat !== 19) begin bad++; $display("FAIL tmo_latency got=%0d want=19", lat); end
        total++; if ({rsp_resp, rsp_timeout, rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
            bad++; $display("FAIL tmo_rsp got=%b/%b/%h want=10/1/0", rsp_resp, rsp_timeout, rsp_rdata);
        end
        total++; if ({arvalid, rready} !== 2'b00) begin bad++; $display("FAIL tmo_quiet got=%b want=00", {arvalid, rready}); end
        consume();
        ar_delay = 0;
    endtask

    task automatic test_back_to_back();
        bit ok, awf; int lat, ac, wc, rc;
        rdata_val = 32'h5A;
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, ok);
        wait_rsp(lat, ac, wc, rc, awf);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; rdata_val = 32'h33;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, 1'b0, 32'h5A, 2'b00, 1'b0}) begin
                bad++; $display("FAIL hold_cycle%0d got=%b/%b/%h want=1/0/5a", i, rsp_valid, cmd_ready, rsp_rdata);
            end
            @(negedge clk);
        end
        consume();
        total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++; $display("FAIL b2b_ready got=%b want=01", {rsp_valid, cmd_ready});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if ({cmd_ready, arvalid} !== 2'b01) begin
            bad++; $display("FAIL b2b_accept got=%b want=01", {cmd_ready, arvalid});
        end
        wait_rsp(lat, ac, wc, rc, awf);
        total++; if ({lat, rsp_rdata, ar_addr_seen} !== {32'd4, 32'h33, 32'h8}) begin
            bad++; $display("FAIL b2b_second got=%0d/%h/%h want=4/33/8", lat, rsp_rdata, ar_addr_seen);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok, awf; int lat, ac, wc, rc;
        aw_delay = 1000; w_delay = 1000;
        do_cmd(1'b1, 32'h4, 32'h9, 4'hF, ok);
        @(negedge clk);
        total++; if (awvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_awvalid got=%b want=1", awvalid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
            bad++; $display("FAIL mid_reset got=%b want=0000001", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        aw_delay = 0; w_delay = 0; rdata_val = 32'h77;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got=%b want=0", rsp_valid); end
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, ok);
        wait_rsp(lat, ac, wc, rc, awf);
        total++; if ({lat, rsp_rdata, rsp_resp, rsp_timeout} !== {32'd4, 32'h77, 2'b00, 1'b0}) begin
            bad++; $display("FAIL mid_read got=%0d/%h/%b/%b want=4/77/00/0", lat, rsp_rdata, rsp_resp, rsp_timeout);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_write_slow_w();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
